// File: rtl/mc_mem_responder_if.sv
// rtl/mc_mem_responder_if.sv - request/response bus between initiator and memory responder
interface mc_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [31:0]           addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  ack_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/mc_mem_responder.sv
// rtl/mc_mem_responder.sv - unified instruction/data memory with fixed wait states
module mc_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  mc_mem_responder_if.slave   bus
);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  access;
  logic                  mem_we;

  // Decode always works from the captured request so late bus changes are harmless.
  assign addr_ok  = (addr_q[1:0] == 2'b00) && (addr_q[31:ADDR_WIDTH+2] == '0);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && addr_ok && we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = !addr_ok;
          if (addr_ok && !we_q) begin
            rdata_d = mem[word_idx];
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage survives reset; a held-low rst suppresses a pending write edge.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[word_idx] <= wdata_q;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = busy_q;
  assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb/tb_mc_mem_responder.sv - directed self-checking bench for mc_mem_responder
module tb_mc_mem_responder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mc_mem_responder_if #(.DATA_WIDTH(32)) bus  ();
  mc_mem_responder_if #(.DATA_WIDTH(32)) bus0 ();

  mc_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mc_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [13];
  int          t_ack [3];
  logic [31:0] exp_b [3];
  int          nack;
  int          lowcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0; bus.we_i = ~we; bus.addr_i = addr ^ 32'h4; bus.wdata_i = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, " busy_wait"}, 32'(bus.busy_o), 32'd1);
      if (bus.ack_o) begin
        lat = i - 1;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd3);
    chk({tag, " err"}, 32'(bus.err_o), 32'(exp_err));
    chk({tag, " rdata"}, bus.rdata_o, exp_rd);
    @(negedge clk);
    chk({tag, " ack_width"}, 32'(bus.ack_o), 32'd0);
    chk({tag, " err_clear"}, 32'(bus.err_o), 32'd0);
    chk({tag, " busy_idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic run_req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    bus0.req_i = 1'b1; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wdata;
    @(posedge clk);
    #1;
    bus0.req_i = 1'b0; bus0.addr_i = addr ^ 32'h4; bus0.wdata_i = ~wdata;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus0.ack_o) begin
        lat = i - 1;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " err"}, 32'(bus0.err_o), 32'(exp_err));
    chk({tag, " rdata"}, bus0.rdata_o, exp_rd);
    @(negedge clk);
    chk({tag, " ack_width"}, 32'(bus0.ack_o), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_000A, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h6666_6666, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h1357_9BDF, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'h1357_9BDF};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h1357_9BDF};
    vecs[11] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h1357_9BDF};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111};
    exp_b[0] = 32'h1111_1111;
    exp_b[1] = 32'h2222_2222;
    exp_b[2] = 32'hDEAD_BEEF;

    rst = 1'b0;
    bus.req_i = 1'b0;  bus.we_i = 1'b0;  bus.addr_i = '0;  bus.wdata_i = '0;
    bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("reset ack", 32'(bus.ack_o), 32'd0);
    chk("reset err", 32'(bus.err_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset rdata", bus.rdata_o, 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 13; v++) begin
      run_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_err, vecs[v].exp_rd,
              $sformatf("vec%0d", v));
    end

    // req held high across three reads; address advances on each ack
    nack = 0;
    lowcnt = 0;
    for (int k = 0; k < 3; k++) t_ack[k] = 0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0;
    for (int c = 0; c < 60 && nack < 3; c++) begin
      @(negedge clk);
      if (bus.ack_o) begin
        t_ack[nack] = c;
        chk($sformatf("b2b rdata%0d", nack), bus.rdata_o, exp_b[nack]);
        nack++;
        if (nack < 3) bus.addr_i = 32'(4 * nack);
        else bus.req_i = 1'b0;
      end else if (!bus.busy_o && nack > 0) begin
        lowcnt++;
      end
    end
    chk("b2b ack count", 32'(nack), 32'd3);
    chk("b2b spacing1", 32'(t_ack[1] - t_ack[0]), 32'd5);
    chk("b2b spacing2", 32'(t_ack[2] - t_ack[1]), 32'd5);
    chk("b2b busy low cycles", 32'(lowcnt), 32'd2);

    // reset during WAIT aborts a pending write to 0x10
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h10; bus.wdata_i = 32'h55;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort ack", 32'(bus.ack_o), 32'd0);
    chk("abort err", 32'(bus.err_o), 32'd0);
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort rdata", bus.rdata_o, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_req(1'b0, 32'h10, 32'h0, 1'b0, 32'h6666_6666, "post_abort read");

    run_req0(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, "w0 write");
    run_req0(1'b0, 32'h20, 32'h0,         1'b0, 32'hCAFE_F00D, "w0 read");
    run_req0(1'b0, 32'h21, 32'h0,         1'b1, 32'hCAFE_F00D, "w0 misaligned");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
